// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD2 hardware write master: FSM state encoding,
// default 50 MHz timing constants, bus width and a parameter range helper.
package lcd_pkg;

   localparam int unsigned LCD_DW = 16;

   // Default timing at 50 MHz
   localparam int unsigned LCD_RST_LOW_CYC  = 50000;    // 1 ms
   localparam int unsigned LCD_RST_WAIT_CYC = 6000000;  // 120 ms
   localparam int unsigned LCD_WR_LOW_CYC   = 2;
   localparam int unsigned LCD_WR_HIGH_CYC  = 2;

   typedef enum logic [2:0] {
      ST_RST_LOW  = 3'd0,
      ST_RST_WAIT = 3'd1,
      ST_IDLE     = 3'd2,
      ST_SETUP    = 3'd3,
      ST_WR_LOW   = 3'd4,
      ST_WR_HIGH  = 3'd5
   } lcd_wr_state_e;

   // True when a cycle count is >= 1 and its terminal value (cyc-1) fits in w bits
   function automatic bit lcd_cyc_fits(input int unsigned cyc, input int unsigned w);
      return (cyc >= 1) && ((64'(cyc) - 64'd1) < (64'd1 << w));
   endfunction

endpackage : lcd_pkg

// File: rtl/lcd_hw_bus_master.sv
// 8080-style write-only master driving the lcd2_*_hw signal set.
// Runs the panel reset sequence after rst_n release or on start_reset (IDLE
// only), then turns each accepted command/data word into one CS/WR cycle:
// SETUP (1) + WR_LOW (WR_LOW_CYC) + WR_HIGH (WR_HIGH_CYC) clocks. A word
// accepted in the last WR_HIGH cycle chains straight into SETUP with CS low.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start_reset        single-cycle request to rerun the panel reset (IDLE only)
//   in_valid/in_ready  word handshake; in_ready is combinational from state
//   in_rs, in_data     register select (0 cmd / 1 data) and 16-bit word
//   busy               high in every state except IDLE
//   lcd2_*_hw          registered panel bus (cs/wr/reset active low, rd tied 1)
module lcd_hw_bus_master
   import lcd_pkg::*;
#(
   parameter int unsigned WR_LOW_CYC   = LCD_WR_LOW_CYC,
   parameter int unsigned WR_HIGH_CYC  = LCD_WR_HIGH_CYC,
   parameter int unsigned RST_LOW_CYC  = LCD_RST_LOW_CYC,
   parameter int unsigned RST_WAIT_CYC = LCD_RST_WAIT_CYC,
   parameter int unsigned CNT_W        = 23
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_rs,
   input  logic [LCD_DW-1:0] in_data,
   output logic              busy,
   output logic              lcd2_cs_hw,
   output logic              lcd2_wr_hw,
   output logic              lcd2_rs_hw,
   output logic              lcd2_reset_hw,
   output logic              lcd2_rd_hw,
   output logic [LCD_DW-1:0] lcd2_data16_hw
);

   // Elaboration-time range checks: every terminal count must fit the counter
   if (!lcd_cyc_fits(WR_LOW_CYC, CNT_W)) begin : g_bad_wr_low
      $fatal(1, "WR_LOW_CYC out of range for CNT_W");
   end
   if (!lcd_cyc_fits(WR_HIGH_CYC, CNT_W)) begin : g_bad_wr_high
      $fatal(1, "WR_HIGH_CYC out of range for CNT_W");
   end
   if (!lcd_cyc_fits(RST_LOW_CYC, CNT_W)) begin : g_bad_rst_low
      $fatal(1, "RST_LOW_CYC out of range for CNT_W");
   end
   if (!lcd_cyc_fits(RST_WAIT_CYC, CNT_W)) begin : g_bad_rst_wait
      $fatal(1, "RST_WAIT_CYC out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] WR_LOW_LAST   = CNT_W'(WR_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] WR_HIGH_LAST  = CNT_W'(WR_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);

   lcd_wr_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              cs_q, cs_d;
   logic              wr_q, wr_d;
   logic              rs_q, rs_d;
   logic              rst_out_q, rst_out_d;
   logic [LCD_DW-1:0] data_q, data_d;

   logic              wr_last_c;
   logic              accept_c;

   // Handshake: free in IDLE unless a reset request wins, or in the last WR_HIGH cycle
   assign wr_last_c = (state_q == ST_WR_HIGH) && (cnt_q == WR_HIGH_LAST);
   assign in_ready  = ((state_q == ST_IDLE) && !start_reset) || wr_last_c;
   assign accept_c  = in_valid && in_ready;
   assign busy      = (state_q != ST_IDLE);

   // Next state, counter and next registered bus values (derived from state_d)
   always_comb begin
      state_d   = state_q;
      rs_d      = rs_q;
      data_d    = data_q;
      cs_d      = 1'b1;
      wr_d      = 1'b1;
      rst_out_d = 1'b1;

      unique case (state_q)
         ST_RST_LOW:  if (cnt_q == RST_LOW_LAST)  state_d = ST_RST_WAIT;
         ST_RST_WAIT: if (cnt_q == RST_WAIT_LAST) state_d = ST_IDLE;
         ST_IDLE: begin
            if (start_reset) begin
               state_d = ST_RST_LOW;
            end else if (accept_c) begin
               state_d = ST_SETUP;
               rs_d    = in_rs;
               data_d  = in_data;
            end
         end
         ST_SETUP:    state_d = ST_WR_LOW;
         ST_WR_LOW:   if (cnt_q == WR_LOW_LAST) state_d = ST_WR_HIGH;
         ST_WR_HIGH: begin
            if (wr_last_c) begin
               if (accept_c) begin
                  state_d = ST_SETUP;
                  rs_d    = in_rs;
                  data_d  = in_data;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default:     state_d = ST_RST_LOW;
      endcase

      unique case (state_d)
         ST_RST_LOW: begin
            rst_out_d = 1'b0;
            // A rerun reset parks the bus the same way rst_n does
            rs_d      = 1'b0;
            data_d    = '0;
         end
         ST_SETUP:   cs_d = 1'b0;
         ST_WR_LOW: begin
            cs_d = 1'b0;
            wr_d = 1'b0;
         end
         ST_WR_HIGH: cs_d = 1'b0;
         default: ;
      endcase

      // Counter restarts on every state entry; IDLE holds it at zero
      if ((state_d != state_q) || (state_q == ST_IDLE)) cnt_d = '0;
      else                                              cnt_d = cnt_q + CNT_W'(1);
   end

   // State and registered panel outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RST_LOW;
         cnt_q     <= '0;
         cs_q      <= 1'b1;
         wr_q      <= 1'b1;
         rs_q      <= 1'b0;
         rst_out_q <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cs_q      <= cs_d;
         wr_q      <= wr_d;
         rs_q      <= rs_d;
         rst_out_q <= rst_out_d;
         data_q    <= data_d;
      end
   end

   assign lcd2_cs_hw     = cs_q;
   assign lcd2_wr_hw     = wr_q;
   assign lcd2_rs_hw     = rs_q;
   assign lcd2_reset_hw  = rst_out_q;
   assign lcd2_rd_hw     = 1'b1;
   assign lcd2_data16_hw = data_q;

endmodule : lcd_hw_bus_master

// File: doc/lcd_hw_bus_master.md
# lcd_hw_bus_master

Hardware-side 8080-style write master for the LCD2 panel bus. It generates the `lcd2_*_hw` signal set that the LCD bus switch selects when the hardware path is enabled. It accepts command/data words over a valid/ready handshake and runs the panel hardware-reset sequence. It converts each accepted word into one CS/WR write cycle with programmable strobe widths. The block is write-only: RD is never asserted.

## Interface
Parameters:
- `WR_LOW_CYC`, default 2: WR low width in clk cycles; legal range ≥1.
- `WR_HIGH_CYC`, default 2: WR high/hold width in clk cycles after the rising edge; legal range ≥1.
- `RST_LOW_CYC`, default 50000: LCD reset low width in cycles (1 ms at 50 MHz).
- `RST_WAIT_CYC`, default 6000000: wait after reset release before the first write (120 ms at 50 MHz).
- `CNT_W`, default 23: internal counter width; must hold `max(all *_CYC) - 1`.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset is asynchronous and active-low.
- `start_reset`  in  1: single-cycle request to rerun the panel reset sequence.
- `in_valid`  in  1: a word is offered.
- `in_ready`  out  1: the block accepts the word this cycle.
- `in_rs`  in  1: 0 = command, 1 = data.
- `in_data`  in  16: word to write.
- `busy`  out  1: high in every state except IDLE.
- `lcd2_cs_hw`  out  1: chip select, active low.
- `lcd2_wr_hw`  out  1: write strobe, active low; the panel latches on the rising edge.
- `lcd2_rs_hw`  out  1: register select.
- `lcd2_reset_hw`  out  1: panel reset, active low.
- `lcd2_rd_hw`  out  1: constant 1.
- `lcd2_data16_hw`  out  16: bus data.

## Operation
- FSM states: RST_LOW, RST_WAIT, IDLE, SETUP, WR_LOW, WR_HIGH.
- While `rst_n` is low, or asynchronously on its assertion:
  - state = RST_LOW, counter = 0.
  - Outputs: cs=1, wr=1, rs=0, reset=0, rd=1, data=16'h0000.
  - `in_ready`=0, `busy`=1.
- RST_LOW: reset=0 for `RST_LOW_CYC` cycles, then RST_WAIT.
- RST_WAIT: reset=1 for `RST_WAIT_CYC` cycles, then IDLE.
- IDLE:
  - cs=1, wr=1.
  - `start_reset`=1 → RST_LOW. Reset wins over `in_valid`; `in_ready`=0 that cycle.
  - Otherwise, `in_valid && in_ready` → latch `in_rs`/`in_data`, go to SETUP.
- SETUP (1 cycle): cs=0, wr=1; rs and data driven from the latched values.
- WR_LOW: wr=0 for `WR_LOW_CYC` cycles; cs, rs and data held.
- WR_HIGH: wr=1 for `WR_HIGH_CYC` cycles; cs, rs and data held.
- Leaving WR_HIGH, in its last cycle:
  - If the handshake fires, latch the new word and go to SETUP; cs stays 0 (back-to-back burst).
  - Otherwise go to IDLE; cs=1, and rs/data keep their last values.
- `in_ready` = (IDLE && !start_reset) || (WR_HIGH && last cycle). Combinational from state and counter.
- `start_reset` outside IDLE is ignored, not queued.
- A `rst_n` assertion mid-write aborts immediately. No partial-cycle completion is guaranteed.

## Timing
- All LCD outputs are registered; none are combinational from the inputs.
- Handshake sampled at edge n → SETUP values visible after edge n.
- Cycles per word:
  - Write cycle = 1 + `WR_LOW_CYC` + `WR_HIGH_CYC` cycles. Defaults: 5 cycles, 10 MHz word rate at 50 MHz.
  - Sustained burst throughput is one word per the same 5 cycles; there are no bubbles.
- Data/RS setup to WR fall: ≥1 cycle. Data hold after WR rise: `WR_HIGH_CYC` cycles.
- Counter:
  - One shared down- or up-counter of `CNT_W` bits, cleared on every state entry.
  - Terminal compare is against `*_CYC - 1`.
  - No wrap-around is permitted: parameter checks fail elaboration when a `*_CYC` value is < 1 or does not fit in `CNT_W`.

## Structure
- Shared package `lcd_pkg`:
  - FSM state enum `lcd_wr_state_e`.
  - Default timing constants at 50 MHz (`LCD_RST_LOW_CYC`, `LCD_RST_WAIT_CYC`, `LCD_WR_LOW_CYC`, `LCD_WR_HIGH_CYC`).
  - Bus width constant `LCD_DW = 16`.
- Single flat module; no sub-modules. The timing counter is inline.

## Test plan
Bench overrides: `RST_LOW_CYC`=10, `RST_WAIT_CYC`=20, WR widths at default.
- Power-up: release `rst_n` → reset=0 for exactly 10 cycles, then 1. `in_ready` first high 30 cycles after release. cs/wr=1 and rd=1 throughout.
- Single write: in_rs=0, in_data=16'h002C in IDLE → cs low for 5 cycles, wr low for cycles 2–3, rs=0 and data=16'h002C stable from SETUP through WR_HIGH. Then IDLE with cs=1.
- Burst: in_valid held with data 16'h1111, 16'h2222, 16'h3333 (rs=1) → three WR pulses 5 cycles apart. cs stays 0 across all three. Each word is accepted in the last WR_HIGH cycle.
- Simultaneous: `start_reset`=1 and `in_valid`=1 in IDLE → no write. Reset sequence reruns, and the word is accepted only after the 30-cycle sequence.
- Ignored request: `start_reset` pulsed during WR_LOW → the write completes normally, no reset pulse follows, and the block returns to IDLE.
- Mid-write reset: assert `rst_n`=0 during WR_LOW → wr=1, cs=1, reset=0 and data=0 immediately (asynchronously). The full power-up sequence runs after release.
